// File: rtl/sdram_responder_pkg.sv
// rtl/sdram_responder_pkg.sv - shared command codes and bus widths for the SDRAM responder
package sdram_responder_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'd0,
    CMD_READ  = 2'd1,
    CMD_WRITE = 2'd2,
    CMD_RSVD  = 2'd3
  } cmd_t;

  localparam int READ_BURST_LENGTH = 4;
  localparam int ADDR_W            = 22;
  localparam int DATA_W            = 32;

endpackage

// File: rtl/sdram_responder_if.sv
// rtl/sdram_responder_if.sv - client <-> responder bus; master is the client, slave the responder
interface sdram_responder_if;
  import sdram_responder_pkg::*;

  logic [1:0]        i_Command;
  logic [ADDR_W-1:0] i_Data_Address;
  logic [DATA_W-1:0] i_Data_Write;
  logic              i_SDRAM_Yield;
  logic [DATA_W-1:0] o_Data_Read;
  logic              o_Data_Read_Valid;
  logic              o_Data_Write_Done;
  logic              o_SDRAM_Requested;
  logic              o_Protocol_Error;

  modport master (
    output i_Command, i_Data_Address, i_Data_Write, i_SDRAM_Yield,
    input  o_Data_Read, o_Data_Read_Valid, o_Data_Write_Done, o_SDRAM_Requested, o_Protocol_Error
  );

  modport slave (
    input  i_Command, i_Data_Address, i_Data_Write, i_SDRAM_Yield,
    output o_Data_Read, o_Data_Read_Valid, o_Data_Write_Done, o_SDRAM_Requested, o_Protocol_Error
  );

endinterface

// File: rtl/sdram_word_ram.sv
// rtl/sdram_word_ram.sv - single-port synchronous-read word RAM backing the responder
module sdram_word_ram
  import sdram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sdram_responder.sv
// rtl/sdram_responder.sv - SDRAM-like responder: latency-delayed read bursts, streamed writes,
// periodic refresh handshake with the client and a sticky protocol-error flag.
module sdram_responder
  import sdram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2       = 12,
  parameter int READ_LATENCY     = 2,
  parameter int REFRESH_INTERVAL = 780,
  parameter int REFRESH_CYCLES   = 8
) (
  input  logic i_Clk,
  input  logic i_Reset,
  sdram_responder_if.slave bus
);

  localparam int RI_W = $clog2(REFRESH_INTERVAL + 1);
  localparam int RC_W = $clog2(REFRESH_CYCLES + 1);
  localparam int WC_W = $clog2(READ_BURST_LENGTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ_WAIT, S_READ_DATA, S_WRITE, S_REFRESH
  } state_t;

  state_t                state;
  logic [DEPTH_LOG2-1:0] ptr;
  logic [3:0]            wait_cnt;
  logic [WC_W-1:0]       word_cnt;
  logic [RI_W-1:0]       ref_cnt;
  logic [RC_W-1:0]       hold_cnt;
  logic                  requested;
  logic                  prot_err;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [DATA_W-1:0]     ram_q;
  logic                  read_valid;
  logic                  write_done;
  logic                  cmd_idle, cmd_read, cmd_write;
  logic                  unused_addr_bits;

  // Code 3 decodes as none of the three, so it behaves as CMD_IDLE everywhere.
  assign cmd_read  = (bus.i_Command == CMD_READ);
  assign cmd_write = (bus.i_Command == CMD_WRITE);
  assign cmd_idle  = !cmd_read && !cmd_write;

  assign read_valid = (state == S_READ_DATA) && cmd_read;
  assign write_done = (state == S_WRITE) && cmd_write;
  assign unused_addr_bits = ^bus.i_Data_Address[ADDR_W-1:DEPTH_LOG2];

  // Synchronous read: in READ_DATA prefetch the word after the one on the output.
  always_comb begin
    ram_addr = ptr;
    if (state == S_WRITE) ram_addr = bus.i_Data_Address[DEPTH_LOG2-1:0];
    else if (state == S_READ_DATA) ram_addr = ptr + DEPTH_LOG2'(1);
  end

  sdram_word_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk   (i_Clk),
    .we    (write_done),
    .addr  (ram_addr),
    .wdata (bus.i_Data_Write),
    .rdata (ram_q)
  );

  assign bus.o_Data_Read       = (state == S_READ_DATA) ? ram_q : '0;
  assign bus.o_Data_Read_Valid = read_valid;
  assign bus.o_Data_Write_Done = write_done;
  assign bus.o_SDRAM_Requested = requested;
  assign bus.o_Protocol_Error  = prot_err;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state     <= S_IDLE;
      ptr       <= '0;
      wait_cnt  <= '0;
      word_cnt  <= '0;
      ref_cnt   <= '0;
      hold_cnt  <= '0;
      requested <= 1'b0;
      prot_err  <= 1'b0;
    end else begin
      // Interval counter freezes while a request is pending or refresh runs.
      if (!requested && state != S_REFRESH) begin
        if (ref_cnt == RI_W'(REFRESH_INTERVAL - 1)) begin
          requested <= 1'b1;
          ref_cnt   <= '0;
        end else begin
          ref_cnt <= ref_cnt + RI_W'(1);
        end
      end

      case (state)
        S_IDLE: begin
          if (bus.i_SDRAM_Yield && !cmd_idle) prot_err <= 1'b1;
          if (requested && bus.i_SDRAM_Yield) begin
            state    <= S_REFRESH;
            hold_cnt <= '0;
          end else if (cmd_read) begin
            state    <= S_READ_WAIT;
            ptr      <= bus.i_Data_Address[DEPTH_LOG2-1:0];
            wait_cnt <= '0;
            word_cnt <= '0;
          end else if (cmd_write) begin
            state <= S_WRITE;
          end
        end
        S_READ_WAIT: begin
          if (cmd_write) begin
            prot_err <= 1'b1;
            state    <= S_IDLE;
          end else if (wait_cnt == 4'(READ_LATENCY - 1)) begin
            state <= S_READ_DATA;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_READ_DATA: begin
          if (cmd_read) begin
            ptr <= ptr + DEPTH_LOG2'(1);
            if (word_cnt == WC_W'(READ_BURST_LENGTH - 1)) state <= S_IDLE;
            else word_cnt <= word_cnt + WC_W'(1);
          end else begin
            if (cmd_write) prot_err <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_WRITE: begin
          if (!cmd_write) begin
            if (cmd_read) prot_err <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_REFRESH: begin
          if (hold_cnt == RC_W'(REFRESH_CYCLES - 1)) begin
            state     <= S_IDLE;
            requested <= 1'b0;
            ref_cnt   <= '0;
          end else begin
            hold_cnt <= hold_cnt + RC_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_responder.sv
// tb/tb_sdram_responder.sv - directed self-checking bench for sdram_responder
module tb_sdram_responder;
  import sdram_responder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  sdram_responder_if bus();

  sdram_responder #(
    .DEPTH_LOG2(12), .READ_LATENCY(2), .REFRESH_INTERVAL(20), .REFRESH_CYCLES(4)
  ) dut (
    .i_Clk(clk), .i_Reset(rst), .bus(bus)
  );

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic do_reset();
    bus.i_Command = CMD_IDLE; bus.i_Data_Address = '0; bus.i_Data_Write = '0; bus.i_SDRAM_Yield = 1'b0;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; cyc = 0;
  endtask

  task automatic write_burst(input logic [21:0] a, input logic [31:0] d0, input string name);
    bus.i_Command = CMD_WRITE; bus.i_Data_Address = a; bus.i_Data_Write = d0;
    @(negedge clk);
    n_cmp++; if (bus.o_Data_Write_Done !== 1'b0) begin n_bad++; $display("FAIL %s_idle_done got %b want 0", name, bus.o_Data_Write_Done); end
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.i_Data_Address = a + 22'(i); bus.i_Data_Write = d0 + 32'(i);
      @(negedge clk);
      n_cmp++; if (bus.o_Data_Write_Done !== 1'b1 || bus.o_Data_Read_Valid !== 1'b0) begin
        n_bad++; $display("FAIL %s_done[%0d] got done=%b valid=%b want 1/0", name, i, bus.o_Data_Write_Done, bus.o_Data_Read_Valid);
      end
      tick();
    end
    bus.i_Command = CMD_IDLE;
    @(negedge clk);
    n_cmp++; if (bus.o_Data_Write_Done !== 1'b0) begin n_bad++; $display("FAIL %s_end_done got %b want 0", name, bus.o_Data_Write_Done); end
    tick();
  endtask

  task automatic read_burst(input logic [21:0] a, input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3, input string name);
    logic [31:0] exp_w [4];
    exp_w = '{e0, e1, e2, e3};
    bus.i_Command = CMD_READ; bus.i_Data_Address = a;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (bus.o_Data_Read_Valid !== 1'b0) begin n_bad++; $display("FAIL %s_lat[%0d] got valid=%b want 0", name, k, bus.o_Data_Read_Valid); end
      tick();
    end
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      n_cmp++; if (bus.o_Data_Read_Valid !== 1'b1 || bus.o_Data_Read !== exp_w[n] || bus.o_Data_Write_Done !== 1'b0) begin
        n_bad++; $display("FAIL %s_word[%0d] got valid=%b data=%h want 1/%h", name, n, bus.o_Data_Read_Valid, bus.o_Data_Read, exp_w[n]);
      end
      tick();
    end
    bus.i_Command = CMD_IDLE;
    @(negedge clk);
    n_cmp++; if (bus.o_Data_Read_Valid !== 1'b0) begin n_bad++; $display("FAIL %s_end got valid=%b want 0", name, bus.o_Data_Read_Valid); end
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++; if (bus.o_Data_Read_Valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", bus.o_Data_Read_Valid); end
    n_cmp++; if (bus.o_Data_Write_Done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", bus.o_Data_Write_Done); end
    n_cmp++; if (bus.o_SDRAM_Requested !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b want 0", bus.o_SDRAM_Requested); end
    n_cmp++; if (bus.o_Protocol_Error !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", bus.o_Protocol_Error); end
    n_cmp++; if (bus.o_Data_Read !== 32'h0) begin n_bad++; $display("FAIL rst_data got %h want 0", bus.o_Data_Read); end
    tick();
  endtask

  task automatic test_write_read();
    write_burst(22'h10, 32'hA0, "wr10");
    read_burst(22'h10, 32'hA0, 32'hA1, 32'hA2, 32'hA3, "rd10");
  endtask

  task automatic test_wrap();
    write_burst(22'hFFE, 32'hB0, "wrwrap");
    read_burst(22'h3FFFFE, 32'hB0, 32'hB1, 32'hB2, 32'hB3, "rdwrap");
  endtask

  task automatic test_cmd_switch();
    do_reset();
    bus.i_Command = CMD_WRITE; bus.i_Data_Address = 22'h30; bus.i_Data_Write = 32'hE0;
    tick();
    @(negedge clk);
    n_cmp++; if (bus.o_Data_Write_Done !== 1'b1) begin n_bad++; $display("FAIL sw_done got %b want 1", bus.o_Data_Write_Done); end
    tick();
    bus.i_Command = CMD_READ;
    @(negedge clk);
    n_cmp++; if (bus.o_Data_Write_Done !== 1'b0 || bus.o_Data_Read_Valid !== 1'b0) begin
      n_bad++; $display("FAIL sw_outputs got done=%b valid=%b want 0/0", bus.o_Data_Write_Done, bus.o_Data_Read_Valid);
    end
    tick();
    bus.i_Command = CMD_IDLE;
    @(negedge clk);
    n_cmp++; if (bus.o_Protocol_Error !== 1'b1) begin n_bad++; $display("FAIL sw_err got %b want 1", bus.o_Protocol_Error); end
    tick();
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    write_burst(22'h20, 32'hD000_0000, "prewr");
    bus.i_Command = CMD_WRITE; bus.i_Data_Address = 22'h20; bus.i_Data_Write = 32'hC0;
    tick();
    for (int i = 0; i < 2; i++) begin
      bus.i_Data_Address = 22'h20 + 22'(i); bus.i_Data_Write = 32'hC0 + 32'(i);
      @(negedge clk);
      n_cmp++; if (bus.o_Data_Write_Done !== 1'b1) begin n_bad++; $display("FAIL mw_done[%0d] got %b want 1", i, bus.o_Data_Write_Done); end
      tick();
    end
    bus.i_Data_Address = 22'h22; bus.i_Data_Write = 32'hC2;
    #1;
    n_cmp++; if (bus.o_Data_Write_Done !== 1'b1) begin n_bad++; $display("FAIL mw_pre_rst_done got %b want 1", bus.o_Data_Write_Done); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.o_Data_Write_Done !== 1'b0) begin n_bad++; $display("FAIL mw_rst_done got %b want 0", bus.o_Data_Write_Done); end
    n_cmp++; if (bus.o_Data_Read_Valid !== 1'b0 || bus.o_SDRAM_Requested !== 1'b0 || bus.o_Protocol_Error !== 1'b0 || bus.o_Data_Read !== 32'h0) begin
      n_bad++; $display("FAIL mw_rst_outs got valid=%b req=%b err=%b data=%h want 0", bus.o_Data_Read_Valid, bus.o_SDRAM_Requested, bus.o_Protocol_Error, bus.o_Data_Read);
    end
    bus.i_Command = CMD_IDLE;
    do_reset();
    read_burst(22'h20, 32'hC0, 32'hC1, 32'hD000_0002, 32'hD000_0003, "mw_rd");
  endtask

  task automatic test_refresh_timing();
    do_reset();
    while (cyc < 19) tick();
    @(negedge clk);
    n_cmp++; if (bus.o_SDRAM_Requested !== 1'b0) begin n_bad++; $display("FAIL ref_c19 got %b want 0", bus.o_SDRAM_Requested); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus.o_SDRAM_Requested !== 1'b1) begin n_bad++; $display("FAIL ref_c20 got %b want 1", bus.o_SDRAM_Requested); end
    while (cyc < 25) tick();
    bus.i_SDRAM_Yield = 1'b1;
    tick();
    bus.i_SDRAM_Yield = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.o_SDRAM_Requested !== 1'b1) begin n_bad++; $display("FAIL ref_c26 got %b want 1", bus.o_SDRAM_Requested); end
    tick();
    bus.i_Command = CMD_READ; bus.i_Data_Address = 22'h10;
    while (cyc < 30) begin
      @(negedge clk);
      n_cmp++; if (bus.o_Data_Read_Valid !== 1'b0 || bus.o_SDRAM_Requested !== 1'b1) begin
        n_bad++; $display("FAIL ref_hold_c%0d got valid=%b req=%b want 0/1", cyc, bus.o_Data_Read_Valid, bus.o_SDRAM_Requested);
      end
      tick();
    end
    @(negedge clk);
    n_cmp++; if (bus.o_SDRAM_Requested !== 1'b0) begin n_bad++; $display("FAIL ref_c30 got %b want 0", bus.o_SDRAM_Requested); end
    tick(); tick();
    @(negedge clk);
    n_cmp++; if (bus.o_Data_Read_Valid !== 1'b0) begin n_bad++; $display("FAIL ref_c32 got valid=%b want 0", bus.o_Data_Read_Valid); end
    tick();
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      n_cmp++; if (bus.o_Data_Read_Valid !== 1'b1 || bus.o_Data_Read !== 32'hA0 + 32'(n)) begin
        n_bad++; $display("FAIL ref_rd[%0d] got valid=%b data=%h want 1/%h", n, bus.o_Data_Read_Valid, bus.o_Data_Read, 32'hA0 + 32'(n));
      end
      tick();
    end
    bus.i_Command = CMD_IDLE;
    @(negedge clk);
    n_cmp++; if (bus.o_Protocol_Error !== 1'b0) begin n_bad++; $display("FAIL ref_err got %b want 0", bus.o_Protocol_Error); end
    tick();
  endtask

  task automatic test_refresh_mid_burst();
    while (cyc < 48) tick();
    bus.i_Command = CMD_READ; bus.i_Data_Address = 22'h3FFFFE;
    tick(); tick();
    @(negedge clk);
    n_cmp++; if (bus.o_SDRAM_Requested !== 1'b1) begin n_bad++; $display("FAIL mb_req_c50 got %b want 1", bus.o_SDRAM_Requested); end
    tick();
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      n_cmp++; if (bus.o_Data_Read_Valid !== 1'b1 || bus.o_Data_Read !== 32'hB0 + 32'(n)) begin
        n_bad++; $display("FAIL mb_rd[%0d] got valid=%b data=%h want 1/%h", n, bus.o_Data_Read_Valid, bus.o_Data_Read, 32'hB0 + 32'(n));
      end
      tick();
    end
    bus.i_Command = CMD_IDLE; bus.i_SDRAM_Yield = 1'b1;
    tick();
    bus.i_SDRAM_Yield = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.o_SDRAM_Requested !== 1'b1) begin n_bad++; $display("FAIL mb_req_c56 got %b want 1", bus.o_SDRAM_Requested); end
    while (cyc < 60) tick();
    @(negedge clk);
    n_cmp++; if (bus.o_SDRAM_Requested !== 1'b0 || bus.o_Protocol_Error !== 1'b0) begin
      n_bad++; $display("FAIL mb_c60 got req=%b err=%b want 0/0", bus.o_SDRAM_Requested, bus.o_Protocol_Error);
    end
    tick();
  endtask

  task automatic test_protocol_error();
    while (cyc < 80) tick();
    bus.i_Command = CMD_READ; bus.i_Data_Address = 22'h10; bus.i_SDRAM_Yield = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.o_SDRAM_Requested !== 1'b1 || bus.o_Protocol_Error !== 1'b0) begin
      n_bad++; $display("FAIL pe_c80 got req=%b err=%b want 1/0", bus.o_SDRAM_Requested, bus.o_Protocol_Error);
    end
    tick();
    bus.i_SDRAM_Yield = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.o_Protocol_Error !== 1'b1) begin n_bad++; $display("FAIL pe_err_set got %b want 1", bus.o_Protocol_Error); end
    while (cyc < 85) tick();
    @(negedge clk);
    n_cmp++; if (bus.o_SDRAM_Requested !== 1'b0) begin n_bad++; $display("FAIL pe_req_c85 got %b want 0", bus.o_SDRAM_Requested); end
    tick(); tick();
    @(negedge clk);
    n_cmp++; if (bus.o_Data_Read_Valid !== 1'b0) begin n_bad++; $display("FAIL pe_c87 got valid=%b want 0", bus.o_Data_Read_Valid); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus.o_Data_Read_Valid !== 1'b1 || bus.o_Data_Read !== 32'hA0) begin
      n_bad++; $display("FAIL pe_c88 got valid=%b data=%h want 1/a0", bus.o_Data_Read_Valid, bus.o_Data_Read);
    end
    tick();
    bus.i_Command = CMD_IDLE;
    @(negedge clk);
    n_cmp++; if (bus.o_Data_Read_Valid !== 1'b0) begin n_bad++; $display("FAIL pe_abort got valid=%b want 0", bus.o_Data_Read_Valid); end
    tick(); tick(); tick();
    @(negedge clk);
    n_cmp++; if (bus.o_Protocol_Error !== 1'b1) begin n_bad++; $display("FAIL pe_sticky got %b want 1", bus.o_Protocol_Error); end
    do_reset();
    @(negedge clk);
    n_cmp++; if (bus.o_Protocol_Error !== 1'b0) begin n_bad++; $display("FAIL pe_cleared got %b want 0", bus.o_Protocol_Error); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_cmd_switch();
    test_reset_mid_write();
    test_refresh_timing();
    test_refresh_mid_burst();
    test_protocol_error();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
